fcmp_sched: RTL and testbench

- Shares one clocked fcmp compare unit among N_REQ requesters.
- Round-robin arbitration selects one request per cycle and drives the operands to the fcmp.
- Each issue is tracked with its requester ID through the fixed fcmp latency.
- The selected result is buffered in a response FIFO with valid/ready backpressure. Credit-based issue guarantees no result is ever dropped.

---
 rtl/fcmp_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_fcmp_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one pipelined fcmp unit among N_REQ requesters.
// Results return through a credit-protected show-ahead response FIFO.

module fcmp_sched_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             push_i,
  input logic             pop_i,
  input logic             full_i,
  input logic [N_REQ-1:0] req_ready_i
);

  // The credit rule must keep the FIFO from ever overflowing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_i && !pop_i));

  // At most one requester is accepted per cycle.
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_i));

endmodule

module fcmp_sched #(
  parameter int N_REQ       = 4,
  parameter int CMP_LATENCY = 1,
  parameter int RESP_DEPTH  = 4,
  parameter int ID_W        = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [N_REQ*32-1:0]  req_a_i,
  input  logic [N_REQ*32-1:0]  req_b_i,
  input  logic [N_REQ*3-1:0]   req_op_i,
  output logic [31:0]          cmp_a_o,
  output logic [31:0]          cmp_b_o,
  input  logic [31:0]          cmp_min_i,
  input  logic [31:0]          cmp_max_i,
  input  logic                 cmp_eq_i,
  input  logic                 cmp_lt_i,
  input  logic                 cmp_le_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [ID_W-1:0]      resp_id_o,
  output logic [31:0]          resp_data_o,
  output logic                 resp_err_o
);

  // One extra tag stage covers the operand register in front of the fcmp.
  localparam int NST   = CMP_LATENCY + 1;
  localparam int PW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int FC_W  = $clog2(RESP_DEPTH + 1);
  localparam int CNT_W = $clog2(RESP_DEPTH + NST + 1) + 1;

  localparam logic [2:0] OP_MIN = 3'd0;
  localparam logic [2:0] OP_MAX = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_LE  = 3'd4;

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return (v >= N_REQ) ? ID_W'(v - N_REQ) : ID_W'(v);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Returns {err, data}.
  function automatic logic [32:0] result_f(input logic [2:0] op,
                                           input logic [31:0] mn,
                                           input logic [31:0] mx,
                                           input logic eq,
                                           input logic lt,
                                           input logic le);
    logic [32:0] r;
    case (op)
      OP_MIN:  r = {1'b0, mn};
      OP_MAX:  r = {1'b0, mx};
      OP_EQ:   r = {1'b0, 31'd0, eq};
      OP_LT:   r = {1'b0, 31'd0, lt};
      OP_LE:   r = {1'b0, 31'd0, le};
      default: r = {1'b1, 32'd0};
    endcase
    return r;
  endfunction

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [31:0]      cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic [NST-1:0]   tag_v_q, tag_v_d;
  logic [ID_W-1:0]  tag_id_q [NST];
  logic [ID_W-1:0]  tag_id_d [NST];
  logic [2:0]       tag_op_q [NST];
  logic [2:0]       tag_op_d [NST];
  logic [ID_W-1:0]  mem_id_q [RESP_DEPTH];
  logic [ID_W-1:0]  mem_id_d [RESP_DEPTH];
  logic [31:0]      mem_data_q [RESP_DEPTH];
  logic [31:0]      mem_data_d [RESP_DEPTH];
  logic             mem_err_q [RESP_DEPTH];
  logic             mem_err_d [RESP_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]  cnt_q, cnt_d;

  logic [CNT_W-1:0] inflight_s, used_s;
  logic             can_issue_s, gnt_found_s, hit_s, hs_s;
  logic [ID_W-1:0]  gnt_idx_s, cand_s;
  logic [N_REQ-1:0] req_ready_s;
  logic             push_s, pop_s, full_s;
  logic [32:0]      res_s;

  // Credit check and round-robin search from the pointer.
  always_comb begin
    inflight_s = '0;
    for (int k = 0; k < NST; k++) begin
      inflight_s = inflight_s + CNT_W'(tag_v_q[k]);
    end
    used_s      = inflight_s + CNT_W'(cnt_q);
    can_issue_s = !rst_i && (used_s < CNT_W'(RESP_DEPTH));
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s      = wrap_idx(int'(ptr_q) + i);
      hit_s       = !gnt_found_s && req_valid_i[cand_s];
      gnt_idx_s   = hit_s ? cand_s : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_s;
    end
    hs_s        = can_issue_s && gnt_found_s;
    req_ready_s = hs_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_s) : '0;
    ptr_d       = hs_s ? wrap_idx(int'(gnt_idx_s) + 1) : ptr_q;
  end

  assign req_ready_o = req_ready_s;

  // Operand registers and tag shift pipeline.
  always_comb begin
    cmp_a_d     = hs_s ? req_a_i[32*int'(gnt_idx_s) +: 32] : cmp_a_q;
    cmp_b_d     = hs_s ? req_b_i[32*int'(gnt_idx_s) +: 32] : cmp_b_q;
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_op_d    = tag_op_q;
    tag_v_d[0]  = hs_s;
    tag_id_d[0] = gnt_idx_s;
    tag_op_d[0] = req_op_i[3*int'(gnt_idx_s) +: 3];
    for (int k = 1; k < NST; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
      tag_op_d[k] = tag_op_q[k-1];
    end
  end

  // Result capture and response FIFO bookkeeping.
  always_comb begin
    push_s = tag_v_q[NST-1];
    pop_s  = (cnt_q != '0) && resp_ready_i;
    full_s = (cnt_q == FC_W'(RESP_DEPTH));
    res_s  = result_f(tag_op_q[NST-1], cmp_min_i, cmp_max_i, cmp_eq_i, cmp_lt_i, cmp_le_i);
    for (int e = 0; e < RESP_DEPTH; e++) begin
      mem_id_d[e]   = (push_s && wr_ptr_q == PW'(e)) ? tag_id_q[NST-1] : mem_id_q[e];
      mem_data_d[e] = (push_s && wr_ptr_q == PW'(e)) ? res_s[31:0]     : mem_data_q[e];
      mem_err_d[e]  = (push_s && wr_ptr_q == PW'(e)) ? res_s[32]       : mem_err_q[e];
    end
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + FC_W'(push_s) - FC_W'(pop_s);
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      tag_v_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < NST; k++) begin
        tag_id_q[k] <= '0;
        tag_op_q[k] <= '0;
      end
      for (int e = 0; e < RESP_DEPTH; e++) begin
        mem_id_q[e]   <= '0;
        mem_data_q[e] <= '0;
        mem_err_q[e]  <= 1'b0;
      end
    end else begin
      ptr_q      <= ptr_d;
      cmp_a_q    <= cmp_a_d;
      cmp_b_q    <= cmp_b_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      tag_op_q   <= tag_op_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_id_q   <= mem_id_d;
      mem_data_q <= mem_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign cmp_a_o      = cmp_a_q;
  assign cmp_b_o      = cmp_b_q;
  assign resp_valid_o = (cnt_q != '0);
  assign resp_id_o    = resp_valid_o ? mem_id_q[rd_ptr_q]   : '0;
  assign resp_data_o  = resp_valid_o ? mem_data_q[rd_ptr_q] : 32'd0;
  assign resp_err_o   = resp_valid_o ? mem_err_q[rd_ptr_q]  : 1'b0;

  fcmp_sched_chk #(.N_REQ(N_REQ)) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .full_i      (full_s),
    .req_ready_i (req_ready_s)
  );

endmodule

// File: tb/tb_fcmp_sched.sv
// Scoreboard bench for fcmp_sched with a behavioural single-cycle fcmp model.

module tb_fcmp_sched;

  localparam int N  = 4;
  localparam int IW = 2;

  localparam logic [31:0] F_1P0 = 32'h3F80_0000;
  localparam logic [31:0] F_2P0 = 32'h4000_0000;
  localparam logic [31:0] F_M1  = 32'hBF80_0000;
  localparam logic [31:0] F_0P5 = 32'h3F00_0000;
  localparam logic [31:0] F_M3  = 32'hC040_0000;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   data;
    logic          err;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready_o;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*3-1:0]  req_op;
  logic [31:0]     cmp_a_o, cmp_b_o;
  logic [31:0]     mdl_min, mdl_max;
  logic            mdl_eq, mdl_lt, mdl_le;
  logic            resp_valid_o, resp_ready, resp_err_o;
  logic [IW-1:0]   resp_id_o;
  logic [31:0]     resp_data_o;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    hs_cnt = 0;

  always #5 clk = ~clk;

  fcmp_sched #(.N_REQ(N), .CMP_LATENCY(1), .RESP_DEPTH(4), .ID_W(IW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .cmp_a_o      (cmp_a_o),
    .cmp_b_o      (cmp_b_o),
    .cmp_min_i    (mdl_min),
    .cmp_max_i    (mdl_max),
    .cmp_eq_i     (mdl_eq),
    .cmp_lt_i     (mdl_lt),
    .cmp_le_i     (mdl_le),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id_o),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o)
  );

  // Ordered key for non-NaN floats; both zeros map to the same key.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    if (x[30:0] == 31'd0) return 32'h8000_0000;
    else if (x[31])       return ~x;
    else                  return x | 32'h8000_0000;
  endfunction

  function automatic logic flt(input logic [31:0] a, input logic [31:0] b);
    return fkey(a) < fkey(b);
  endfunction

  function automatic logic feq(input logic [31:0] a, input logic [31:0] b);
    return fkey(a) == fkey(b);
  endfunction

  function automatic resp_t exp_result(input int id, input logic [31:0] a,
                                       input logic [31:0] b, input logic [2:0] op);
    resp_t r;
    r.id  = IW'(id);
    r.err = 1'b0;
    case (op)
      3'd0:    r.data = flt(a, b) ? a : b;
      3'd1:    r.data = flt(a, b) ? b : a;
      3'd2:    r.data = {31'd0, feq(a, b)};
      3'd3:    r.data = {31'd0, flt(a, b)};
      3'd4:    r.data = {31'd0, flt(a, b) | feq(a, b)};
      default: begin r.data = 32'd0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    mdl_min <= flt(cmp_a_o, cmp_b_o) ? cmp_a_o : cmp_b_o;
    mdl_max <= flt(cmp_a_o, cmp_b_o) ? cmp_b_o : cmp_a_o;
    mdl_eq  <= feq(cmp_a_o, cmp_b_o);
    mdl_lt  <= flt(cmp_a_o, cmp_b_o);
    mdl_le  <= flt(cmp_a_o, cmp_b_o) | feq(cmp_a_o, cmp_b_o);
  end

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    int    g;
    resp_t e;
    if (!rst) begin
      if (|(req_ready_o & req_valid)) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
        checks++;
        if (!$onehot(req_ready_o) || ((req_ready_o & ~req_valid) != '0)) begin
          errors++;
          $display("FAIL ready_onehot: got req_ready=%b with req_valid=%b", req_ready_o, req_valid);
        end
        exp_q.push_back(exp_result(g, req_a[32*g +: 32], req_b[32*g +: 32], req_op[3*g +: 3]));
        hs_cnt++;
      end
      if (resp_valid_o && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got id=%0d data=%h err=%b with nothing expected",
                   resp_id_o, resp_data_o, resp_err_o);
        end else begin
          e = exp_q.pop_front();
          if ({resp_id_o, resp_data_o, resp_err_o} !== e) begin
            errors++;
            $display("FAIL resp_order: got id=%0d data=%h err=%b expected id=%0d data=%h err=%b",
                     resp_id_o, resp_data_o, resp_err_o, e.id, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    exp_q.delete();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid  = '0;
    resp_ready = 1'b1;
    while ((exp_q.size() != 0 || resp_valid_o) && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || resp_valid_o) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding, resp_valid=%b, expected 0",
               exp_q.size(), resp_valid_o);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b1;
    repeat (2) cyc();
    checks += 7;
    if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready_o); end
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", resp_valid_o); end
    if (resp_id_o !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d expected 0", resp_id_o); end
    if (resp_data_o !== 32'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", resp_data_o); end
    if (resp_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", resp_err_o); end
    if (cmp_a_o !== 32'd0) begin errors++; $display("FAIL rst_cmp_a: got %h expected 0", cmp_a_o); end
    if (cmp_b_o !== 32'd0) begin errors++; $display("FAIL rst_cmp_b: got %h expected 0", cmp_b_o); end
    req_valid = '0;
    rst       = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    logic [2:0]  ops  [2] = '{3'd3, 3'd0};
    logic [31:0] exps [2] = '{32'h0000_0001, F_1P0};
    for (int t = 0; t < 2; t++) begin
      set_req(0, F_1P0, F_2P0, ops[t]);
      req_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready_o); end
      cyc();
      req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checks++;
        if (resp_valid_o !== (c == 3)) begin
          errors++;
          $display("FAIL single_latency: cycle %0d got resp_valid=%b expected %b", c, resp_valid_o, (c == 3));
        end
        if (c == 3) begin
          checks++;
          if (resp_data_o !== exps[t] || resp_id_o !== 2'd0 || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL single_data: got id=%0d data=%h err=%b expected id=0 data=%h err=0",
                     resp_id_o, resp_data_o, resp_err_o, exps[t]);
          end
        end
        cyc();
      end
    end
    drain();
  endtask

  task automatic test_rotate();
    do_reset();
    set_req(0, F_1P0, F_2P0, 3'd0);
    set_req(1, F_M1,  F_0P5, 3'd1);
    set_req(2, F_0P5, F_0P5, 3'd2);
    set_req(3, F_M3,  F_M1,  3'd3);
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready_o !== (4'b0001 << (k % 4))) begin
        errors++;
        $display("FAIL rotate_grant: cycle %0d got %b expected %b", k, req_ready_o, 4'b0001 << (k % 4));
      end
      if (k >= 3) begin
        checks++;
        if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL rotate_rate: cycle %0d got resp_valid=%b expected 1", k, resp_valid_o); end
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_stall();
    int h0;
    resp_ready = 1'b0;
    req_valid  = '1;
    h0 = hs_cnt;
    repeat (8) cyc();
    @(negedge clk);
    checks += 2;
    if (hs_cnt - h0 != 4) begin errors++; $display("FAIL stall_count: got %0d handshakes expected 4", hs_cnt - h0); end
    if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL stall_ready: got %b expected 0000", req_ready_o); end
    cyc();
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    h0 = hs_cnt;
    repeat (4) cyc();
    checks++;
    if (hs_cnt - h0 != 1) begin errors++; $display("FAIL stall_resume: got %0d handshakes expected 1", hs_cnt - h0); end
    drain();
  endtask

  task automatic test_illegal();
    logic [2:0]  ops  [2] = '{3'd6, 3'd2};
    logic [31:0] exps [2] = '{32'd0, 32'h0000_0001};
    logic        errs [2] = '{1'b1, 1'b0};
    int n;
    resp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      set_req(2, F_0P5, F_0P5, ops[t]);
      req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL illegal_grant: got %b expected 0100", req_ready_o); end
      cyc();
      req_valid = '0;
      n = 0;
      @(negedge clk);
      while (!resp_valid_o && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (!resp_valid_o) begin
        errors++;
        $display("FAIL illegal_timeout: got no response expected one within 10 cycles");
      end else if (resp_id_o !== 2'd2 || resp_data_o !== exps[t] || resp_err_o !== errs[t]) begin
        errors++;
        $display("FAIL illegal_resp: got id=%0d data=%h err=%b expected id=2 data=%h err=%b",
                 resp_id_o, resp_data_o, resp_err_o, exps[t], errs[t]);
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    set_req(2, F_2P0, F_1P0, 3'd1);
    set_req(0, F_M1, F_1P0, 3'd4);
    req_valid = 4'b0100;
    repeat (3) cyc();
    req_valid = '0;
    cyc();
    checks++;
    if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre: got resp_valid=%b expected 1", resp_valid_o); end
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || resp_data_o !== 32'd0 || resp_id_o !== 2'd0 ||
        resp_err_o !== 1'b0 || cmp_a_o !== 32'd0 || req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_zero: got valid=%b id=%0d data=%h err=%b cmp_a=%h ready=%b expected all 0",
               resp_valid_o, resp_id_o, resp_data_o, resp_err_o, cmp_a_o, req_ready_o);
    end
    exp_q.delete();
    repeat (2) cyc();
    rst        = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", req_ready_o); end
    cyc();
    drain();
  endtask

  task automatic test_ptr();
    logic [3:0] vals [3] = '{4'b1000, 4'b1010, 4'b1010};
    logic [3:0] gnts [3] = '{4'b1000, 4'b0010, 4'b1000};
    set_req(1, F_M3, F_M1, 3'd0);
    set_req(3, F_1P0, F_M1, 3'd4);
    resp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req_valid = vals[t];
      @(negedge clk);
      checks++;
      if (req_ready_o !== gnts[t]) begin
        errors++;
        $display("FAIL ptr_grant: step %0d got %b expected %b", t, req_ready_o, gnts[t]);
      end
      cyc();
    end
    drain();
  endtask

  initial begin
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_ptr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
